cache_bus2_master: RTL and testbench

//  Cache-side master of the memory bus (A2/D2/C2). It is the stage directly upstream of the memory controller.
//  It accepts one line request from the cache, either a 16-byte read-fill or a 16-byte write-back.
//  It runs the C2 command/response handshake and moves the line as 8 x 16-bit beats on D2.
//  It returns the fill line to the cache with a one-cycle completion pulse.

---
 rtl/bus2_pkg.sv | 27 ++
 rtl/line_shifter.sv | 47 ++++
 rtl/cache_bus2_master.sv | 204 ++++++++++++++++++++
 tb/tb_cache_bus2_master.sv | 367 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bus2_pkg.sv
// Shared definitions for the A2/D2/C2 memory bus: widths, command codes and
// the cache-side master state type.
package bus2_pkg;

  localparam int unsigned BUS2_A_W   = 14;
  localparam int unsigned BUS2_D_W   = 16;
  localparam int unsigned LINE_BEATS = 8;
  localparam int unsigned LINE_BITS  = LINE_BEATS * BUS2_D_W;

  typedef enum logic [1:0] {
    C2_NOP        = 2'b00,
    C2_RESPONSE   = 2'b01,
    C2_READ_LINE  = 2'b10,
    C2_WRITE_LINE = 2'b11
  } c2_cmd_e;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RD_CMD  = 3'd1,
    ST_RD_WAIT = 3'd2,
    ST_RD_BEAT = 3'd3,
    ST_WR_BEAT = 3'd4,
    ST_WR_TAIL = 3'd5,
    ST_DONE    = 3'd6
  } state_e;

endpackage

// File: rtl/line_shifter.sv
// Line-wide shift register: parallel load, beat-0-first shift-out for writes,
// and shift-in at the top so that beat 0 lands at the bottom after a full read.
module line_shifter
  import bus2_pkg::*;
#(
  parameter int unsigned D_W   = BUS2_D_W,
  parameter int unsigned BEATS = LINE_BEATS
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 load_i,
  input  logic                 shift_in_i,
  input  logic                 shift_out_i,
  input  logic [BEATS*D_W-1:0] line_i,
  input  logic [D_W-1:0]       beat_i,
  output logic [D_W-1:0]       beat_o,
  output logic [BEATS*D_W-1:0] line_next_o
);

  localparam int unsigned W = BEATS * D_W;

  logic [W-1:0] line_q;
  logic [W-1:0] line_d;

  always_comb begin
    line_d = line_q;
    if (load_i) begin
      line_d = line_i;
    end else if (shift_in_i) begin
      line_d = {beat_i, line_q[W-1:D_W]};
    end else if (shift_out_i) begin
      line_d = {{D_W{1'b0}}, line_q[W-1:D_W]};
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      line_q <= '0;
    end else begin
      line_q <= line_d;
    end
  end

  assign beat_o      = line_q[D_W-1:0];
  assign line_next_o = line_d;

endmodule

// File: rtl/cache_bus2_master.sv
// Cache-side master of the A2/D2/C2 memory bus: moves one 128-bit line per
// request as 16-bit beats, with a C2 command/response handshake.
module cache_bus2_master
  import bus2_pkg::*;
#(
  parameter int unsigned A2_W         = BUS2_A_W,
  parameter int unsigned D_W          = BUS2_D_W,
  parameter int unsigned BEATS        = LINE_BEATS,
  parameter int unsigned RESP_TIMEOUT = 255,
  parameter int unsigned WR_TAIL      = 92
) (
  input  logic                 clk,
  input  logic                 RESET,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_we,
  input  logic [A2_W-1:0]      req_addr,
  input  logic [BEATS*D_W-1:0] req_wdata,
  output logic                 rsp_valid,
  output logic                 rsp_err,
  output logic [BEATS*D_W-1:0] rsp_rdata,
  output logic [A2_W-1:0]      A2,
  inout  wire  [D_W-1:0]       D2,
  inout  wire  [1:0]           C2
);

  localparam int unsigned LW = BEATS * D_W;
  localparam int unsigned HW = D_W / 2;
  localparam int unsigned BW = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int unsigned WW = $clog2(RESP_TIMEOUT + 1);
  localparam int unsigned TW = $clog2(WR_TAIL + 1);

  localparam logic [BW-1:0] BEAT_LAST = BW'(BEATS - 1);
  localparam logic [WW-1:0] WAIT_LAST = WW'(RESP_TIMEOUT - 1);
  localparam logic [TW-1:0] TAIL_LAST = TW'(WR_TAIL - 1);

  state_e          state_q, state_d;
  logic [BW-1:0]   beat_q, beat_d;
  logic [WW-1:0]   wait_q, wait_d;
  logic [TW-1:0]   tail_q, tail_d;
  logic            err_q, err_d;
  logic [A2_W-1:0] addr_q, addr_d;
  logic [LW-1:0]   rdata_q, rdata_d;

  logic            sh_load, sh_in, sh_out;
  logic [D_W-1:0]  sh_beat;
  logic [LW-1:0]   sh_line_next;
  logic [D_W-1:0]  d2_in;
  logic            c2_resp;
  logic            c2_oe, d2_oe;
  logic [1:0]      c2_out;
  logic [D_W-1:0]  d2_out;

  // Beat i carries byte 2i in its upper half, so halves swap on both paths.
  assign d2_in   = {D2[HW-1:0], D2[D_W-1:HW]};
  assign d2_out  = {sh_beat[HW-1:0], sh_beat[D_W-1:HW]};
  assign c2_resp = (C2 == C2_RESPONSE);

  line_shifter #(
    .D_W   (D_W),
    .BEATS (BEATS)
  ) u_shifter (
    .clk_i       (clk),
    .rst_ni      (RESET),
    .load_i      (sh_load),
    .shift_in_i  (sh_in),
    .shift_out_i (sh_out),
    .line_i      (req_wdata),
    .beat_i      (d2_in),
    .beat_o      (sh_beat),
    .line_next_o (sh_line_next)
  );

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    wait_d  = wait_q;
    tail_d  = tail_q;
    err_d   = err_q;
    addr_d  = addr_q;
    rdata_d = rdata_q;
    sh_load = 1'b0;
    sh_in   = 1'b0;
    sh_out  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          addr_d  = req_addr;
          sh_load = 1'b1;
          beat_d  = '0;
          wait_d  = '0;
          tail_d  = '0;
          state_d = req_we ? ST_WR_BEAT : ST_RD_CMD;
        end
      end
      ST_RD_CMD: begin
        wait_d  = '0;
        state_d = ST_RD_WAIT;
      end
      ST_RD_WAIT: begin
        if (c2_resp) begin
          sh_in   = 1'b1;
          beat_d  = BW'(1);
          state_d = ST_RD_BEAT;
        end else if (wait_q == WAIT_LAST) begin
          err_d   = 1'b1;
          state_d = ST_DONE;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      ST_RD_BEAT: begin
        if (c2_resp) begin
          sh_in = 1'b1;
          if (beat_q == BEAT_LAST) begin
            // Commit on the final beat's edge so the line is valid with rsp_valid.
            rdata_d = sh_line_next;
            err_d   = 1'b0;
            state_d = ST_DONE;
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end else begin
          err_d   = 1'b1;
          state_d = ST_DONE;
        end
      end
      ST_WR_BEAT: begin
        sh_out = 1'b1;
        if (beat_q == BEAT_LAST) begin
          tail_d  = '0;
          state_d = ST_WR_TAIL;
        end else begin
          beat_d = beat_q + 1'b1;
        end
      end
      ST_WR_TAIL: begin
        if (tail_q == TAIL_LAST) begin
          err_d   = 1'b0;
          state_d = ST_DONE;
        end else begin
          tail_d = tail_q + 1'b1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge RESET) begin
    if (!RESET) begin
      state_q <= ST_IDLE;
      beat_q  <= '0;
      wait_q  <= '0;
      tail_q  <= '0;
      err_q   <= 1'b0;
      addr_q  <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      wait_q  <= wait_d;
      tail_q  <= tail_d;
      err_q   <= err_d;
      addr_q  <= addr_d;
      rdata_q <= rdata_d;
    end
  end

  // Bus enables decode straight from the state so reset releases them at once.
  always_comb begin
    c2_oe  = 1'b0;
    d2_oe  = 1'b0;
    c2_out = C2_NOP;
    case (state_q)
      ST_RD_CMD: begin
        c2_oe  = 1'b1;
        c2_out = C2_READ_LINE;
      end
      ST_WR_BEAT: begin
        c2_oe  = 1'b1;
        d2_oe  = 1'b1;
        c2_out = C2_WRITE_LINE;
      end
      default: begin
        c2_oe = 1'b0;
      end
    endcase
  end

  assign C2 = c2_oe ? c2_out : 'z;
  assign D2 = d2_oe ? d2_out : 'z;

  assign A2        = addr_q;
  assign req_ready = (state_q == ST_IDLE);
  assign rsp_valid = (state_q == ST_DONE);
  assign rsp_err   = err_q;
  assign rsp_rdata = rdata_q;

endmodule

// File: tb/tb_cache_bus2_master.sv
// Bench for cache_bus2_master: a memory-side bus model plus a line-level
// reference for beat/byte mapping, handshake timing and error outcomes.
module tb_cache_bus2_master;

  logic         clk;
  logic         RESET;
  logic         req_valid;
  logic         req_ready;
  logic         req_we;
  logic [13:0]  req_addr;
  logic [127:0] req_wdata;
  logic         rsp_valid;
  logic         rsp_err;
  logic [127:0] rsp_rdata;
  logic [13:0]  a2;
  tri0  [15:0]  d2;
  tri0  [1:0]   c2;

  logic         mem_drv;
  logic [1:0]   mem_c2;
  logic [15:0]  mem_d2;
  logic [15:0]  mem_beats [8];
  logic [127:0] last_line;

  int n_tests;
  int n_fail;

  assign c2 = mem_drv ? mem_c2 : 2'bzz;
  assign d2 = mem_drv ? mem_d2 : 16'hzzzz;

  cache_bus2_master #(
    .A2_W         (14),
    .D_W          (16),
    .BEATS        (8),
    .RESP_TIMEOUT (255),
    .WR_TAIL      (92)
  ) dut (
    .clk       (clk),
    .RESET     (RESET),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_err   (rsp_err),
    .rsp_rdata (rsp_rdata),
    .A2        (a2),
    .D2        (d2),
    .C2        (c2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Byte 2i of the line travels in the upper half of beat i.
  function automatic logic [127:0] line_from_beats();
    logic [127:0] l;
    l = '0;
    for (int i = 0; i < 8; i++) begin
      l[8*(2*i)   +: 8] = mem_beats[i][15:8];
      l[8*(2*i+1) +: 8] = mem_beats[i][7:0];
    end
    return l;
  endfunction

  function automatic logic [15:0] beat_of_line(input logic [127:0] l, input int i);
    return {l[8*(2*i) +: 8], l[8*(2*i+1) +: 8]};
  endfunction

  task automatic accept(input logic [13:0] addr, input logic we, input logic [127:0] wdata);
    @(negedge clk);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    for (int g = 0; g < 20 && !req_ready; g++) @(negedge clk);
    n_tests++;
    if (req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL accept_ready: req_ready=%b expected 1", req_ready);
    end
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  // nsend: 0 = memory never answers, 1..7 = short burst, 8 = full line.
  task automatic run_read(input string nm, input logic [13:0] addr, input int dly,
                          input int nsend, input bit rand_beats);
    int           exp_c;
    int           done_c;
    logic         exp_err;
    logic [127:0] exp_line;
    if (rand_beats)
      for (int i = 0; i < 8; i++) mem_beats[i] = 16'($urandom);
    if (nsend == 0)      exp_c = 1 + 255;
    else if (nsend >= 8) exp_c = dly + 8;
    else                 exp_c = dly + nsend + 1;
    exp_err  = (nsend < 8);
    exp_line = exp_err ? last_line : line_from_beats();
    accept(addr, 1'b0, {$urandom, $urandom, $urandom, $urandom});
    done_c = -1;
    for (int c = 0; c < 400; c++) begin
      if (c == 0) begin
        n_tests++;
        if (c2 !== 2'b10 || a2 !== addr || d2 !== 16'h0000) begin
          n_fail++;
          $display("FAIL %s_rd_cmd: c2=%b a2=%h d2=%h expected c2=10 a2=%h d2=0000", nm, c2, a2, d2, addr);
        end
      end
      if (c == 1) begin
        n_tests++;
        if (c2 !== 2'b00 || d2 !== 16'h0000) begin
          n_fail++;
          $display("FAIL %s_rd_release: c2=%b d2=%h expected released", nm, c2, d2);
        end
      end
      if (rsp_valid === 1'b1) begin
        done_c = c;
        break;
      end
      if (nsend > 0 && c >= dly && c < dly + nsend) begin
        mem_drv = 1'b1;
        mem_c2  = 2'b01;
        mem_d2  = mem_beats[c - dly];
      end else begin
        mem_drv = 1'b0;
      end
      @(negedge clk);
    end
    mem_drv = 1'b0;
    n_tests++;
    if (done_c != exp_c) begin
      n_fail++;
      $display("FAIL %s_latency: rsp_valid at cycle %0d expected %0d", nm, done_c, exp_c);
    end
    n_tests++;
    if (rsp_err !== exp_err) begin
      n_fail++;
      $display("FAIL %s_err: rsp_err=%b expected %b", nm, rsp_err, exp_err);
    end
    n_tests++;
    if (rsp_rdata !== exp_line) begin
      n_fail++;
      $display("FAIL %s_rdata: got %h expected %h", nm, rsp_rdata, exp_line);
    end
    @(negedge clk);
    n_tests++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_pulse: rsp_valid=%b req_ready=%b expected 0/1", nm, rsp_valid, req_ready);
    end
    if (!exp_err) last_line = exp_line;
  endtask

  task automatic run_write(input string nm, input logic [13:0] addr, input logic [127:0] wdata);
    int          done_c;
    logic [17:0] exp_bus;
    accept(addr, 1'b1, wdata);
    done_c = -1;
    for (int c = 0; c < 130; c++) begin
      if (rsp_valid === 1'b1) begin
        done_c = c;
        break;
      end
      exp_bus = (c < 8) ? {2'b11, beat_of_line(wdata, c)} : 18'h0;
      n_tests++;
      if ({c2, d2} !== exp_bus || a2 !== addr) begin
        n_fail++;
        $display("FAIL %s_wr_bus c%0d: c2=%b d2=%h a2=%h expected c2=%b d2=%h a2=%h",
                 nm, c, c2, d2, a2, exp_bus[17:16], exp_bus[15:0], addr);
      end
      @(negedge clk);
    end
    n_tests++;
    if (done_c != 8 + 92) begin
      n_fail++;
      $display("FAIL %s_wr_latency: rsp_valid at cycle %0d expected %0d", nm, done_c, 100);
    end
    n_tests++;
    if (rsp_err !== 1'b0 || rsp_rdata !== last_line) begin
      n_fail++;
      $display("FAIL %s_wr_rsp: err=%b rdata=%h expected err=0 rdata=%h", nm, rsp_err, rsp_rdata, last_line);
    end
    @(negedge clk);
    n_tests++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_wr_pulse: rsp_valid=%b req_ready=%b expected 0/1", nm, rsp_valid, req_ready);
    end
  endtask

  task automatic test_reset();
    #2 RESET = 1'b0;
    @(negedge clk);
    n_tests++;
    if ({req_ready, rsp_valid, rsp_err} !== 3'b100 || rsp_rdata !== 128'h0 ||
        a2 !== 14'h0 || c2 !== 2'b00 || d2 !== 16'h0000) begin
      n_fail++;
      $display("FAIL reset_state: ready=%b valid=%b err=%b rdata=%h a2=%h c2=%b d2=%h expected 1 0 0 0 0 00 0000",
               req_ready, rsp_valid, rsp_err, rsp_rdata, a2, c2, d2);
    end
    @(negedge clk);
    RESET = 1'b1;
    last_line = '0;
  endtask

  task automatic test_read();
    for (int i = 0; i < 8; i++) mem_beats[i] = {8'(2*i + 1), 8'(2*i)};
    run_read("read", 14'h0012, 10, 8, 1'b0);
    n_tests++;
    if (rsp_rdata[7:0] !== 8'h01 || rsp_rdata[15:8] !== 8'h00 || rsp_rdata[23:16] !== 8'h03) begin
      n_fail++;
      $display("FAIL read_bytes: low bytes %h expected 030001", rsp_rdata[23:0]);
    end
  endtask

  task automatic test_write();
    logic [127:0] w;
    for (int k = 0; k < 16; k++) w[8*k +: 8] = 8'(k);
    run_write("write", 14'h0a5c, w);
  endtask

  task automatic test_timeout();
    run_read("timeout", 14'h1234, 0, 0, 1'b1);
  endtask

  task automatic test_short_burst();
    run_read("short", 14'h0777, 4, 5, 1'b1);
  endtask

  task automatic test_reset_mid_write();
    logic [127:0] w;
    int           stray;
    w = {$urandom, $urandom, $urandom, $urandom};
    accept(14'h2abc, 1'b1, w);
    repeat (3) @(negedge clk);
    n_tests++;
    if (c2 !== 2'b11 || d2 !== beat_of_line(w, 3)) begin
      n_fail++;
      $display("FAIL rstw_beat3: c2=%b d2=%h expected 11 %h", c2, d2, beat_of_line(w, 3));
    end
    #2 RESET = 1'b0;
    #1;
    n_tests++;
    if (c2 !== 2'b00 || d2 !== 16'h0000 || a2 !== 14'h0 || rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL rstw_async: c2=%b d2=%h a2=%h valid=%b ready=%b expected 00 0000 0 0 1",
               c2, d2, a2, rsp_valid, req_ready);
    end
    @(negedge clk);
    RESET = 1'b1;
    last_line = '0;
    stray = 0;
    for (int c = 0; c < 110; c++) begin
      @(negedge clk);
      if (rsp_valid !== 1'b0 || req_ready !== 1'b1) stray++;
    end
    n_tests++;
    if (stray != 0) begin
      n_fail++;
      $display("FAIL rstw_idle: %0d cycles not idle expected 0", stray);
    end
  endtask

  task automatic test_back_to_back();
    logic [127:0] exp_line;
    int           accepts, acc_before, first, second, done_c, rel, wait_c;
    for (int i = 0; i < 8; i++) mem_beats[i] = 16'($urandom);
    exp_line = line_from_beats();
    @(negedge clk);
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_addr  = 14'h0101;
    accepts = 0; acc_before = 0; first = -1; second = -1; done_c = -1;
    for (int c = 0; c < 100; c++) begin
      if (rsp_valid === 1'b1 && done_c < 0) begin
        done_c = c;
        n_tests++;
        if (req_ready !== 1'b0 || rsp_err !== 1'b0 || rsp_rdata !== exp_line) begin
          n_fail++;
          $display("FAIL b2b_done: ready=%b err=%b rdata=%h expected 0 0 %h", req_ready, rsp_err, rsp_rdata, exp_line);
        end
      end
      if (req_ready === 1'b1) begin
        accepts++;
        if (first < 0) first = c;
        else second = c;
        if (done_c < 0) acc_before++;
      end
      if (accepts == 2) break;
      rel = (first < 0) ? -1 : c - (first + 1);
      if (rel >= 3 && rel < 11) begin
        mem_drv = 1'b1;
        mem_c2  = 2'b01;
        mem_d2  = mem_beats[rel - 3];
      end else begin
        mem_drv = 1'b0;
      end
      @(negedge clk);
    end
    mem_drv = 1'b0;
    n_tests++;
    if (acc_before != 1) begin
      n_fail++;
      $display("FAIL b2b_single: %0d accepts before DONE expected 1", acc_before);
    end
    n_tests++;
    if (done_c < 0 || second != done_c + 1) begin
      n_fail++;
      $display("FAIL b2b_second: second accept at %0d expected %0d", second, done_c + 1);
    end
    last_line = exp_line;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    wait_c = -1;
    for (int c = 0; c < 300; c++) begin
      if (rsp_valid === 1'b1) begin
        wait_c = c;
        break;
      end
      @(negedge clk);
    end
    n_tests++;
    if (wait_c != 256 || rsp_err !== 1'b1 || rsp_rdata !== last_line) begin
      n_fail++;
      $display("FAIL b2b_followup: cycle %0d err=%b expected cycle 256 err=1", wait_c, rsp_err);
    end
    @(negedge clk);
  endtask

  task automatic test_random();
    for (int t = 0; t < 6; t++) begin
      if ($urandom_range(0, 1) == 1)
        run_write("rnd_wr", 14'($urandom), {$urandom, $urandom, $urandom, $urandom});
      else
        run_read("rnd_rd", 14'($urandom), int'($urandom_range(2, 20)), int'($urandom_range(1, 8)), 1'b1);
    end
  endtask

  initial begin
    n_tests   = 0;
    n_fail    = 0;
    RESET     = 1'b1;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    mem_drv   = 1'b0;
    mem_c2    = 2'b00;
    mem_d2    = '0;
    last_line = '0;
    test_reset();
    test_read();
    test_write();
    test_timeout();
    test_short_burst();
    test_reset_mid_write();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
